// File: rtl/xgmii_tx_rate_fifo.sv
// XGMII transmit buffer: absorbs MAC words in a small FIFO and emits a continuous
// stream to the PCS, deleting idles under back-pressure and flagging mid-frame underruns.
module xgmii_tx_rate_fifo #(
  parameter int LANES = 8,
  parameter int DEPTH = 16,
  parameter int AFULL = DEPTH - 4
) (
  input  logic                       TX_CLK,
  input  logic                       rst_s_i,
  input  logic [8*LANES-1:0]         TXD,
  input  logic [LANES-1:0]           TXC,
  input  logic                       VALID,
  output logic                       READY,
  input  logic                       rd_en_i,
  output logic [8*LANES-1:0]         XD_O,
  output logic [LANES-1:0]           XC_O,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       overflow_o,
  output logic                       underrun_o,
  output logic [15:0]                idle_drop_cnt_o,
  output logic [15:0]                underrun_cnt_o
);

  localparam int DW = 8 * LANES;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] AFULL_L = LW'(AFULL);
  localparam logic [DW-1:0] IDLE_D  = {LANES{8'h07}};
  localparam logic [DW-1:0] ERR_D   = {LANES{8'hFE}};

  typedef enum logic [1:0] {S_IDLE, S_FRAME, S_DRAIN} state_t;

  function automatic logic f_is_idle(input logic [DW-1:0] d, input logic [LANES-1:0] c);
    return (&c) && (d == IDLE_D);
  endfunction

  function automatic logic f_is_start(input logic [DW-1:0] d, input logic [LANES-1:0] c);
    return c[0] && (d[7:0] == 8'hFB);
  endfunction

  function automatic logic f_is_term(input logic [DW-1:0] d, input logic [LANES-1:0] c);
    logic t;
    t = 1'b0;
    for (int i = 0; i < LANES; i++)
      if (c[i] && (d[8*i +: 8] == 8'hFD)) t = 1'b1;
    return t;
  endfunction

  logic [DW+LANES-1:0] mem [DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [LW-1:0]       count;
  state_t              state, state_nx;
  logic [DW-1:0]       xd_nx, head_d;
  logic [LANES-1:0]    xc_nx, head_c;
  logic                push, pop, empty, ur_nx, in_idle;

  assign READY   = (count < AFULL_L);
  assign level_o = count;
  assign push    = VALID && READY;
  assign empty   = (count == '0);
  assign in_idle = f_is_idle(TXD, TXC);
  assign {head_c, head_d} = mem[rd_ptr];

  // NOTE: storage has no reset; emptiness is tracked by count, so stale entries are never read.
  always_ff @(posedge TX_CLK) begin
    if (push) mem[wr_ptr] <= {TXC, TXD};
  end

  // NOTE: every signal assigned below gets a default first so no latch is inferred.
  always_comb begin
    state_nx = state;
    xd_nx    = XD_O;
    xc_nx    = XC_O;
    ur_nx    = 1'b0;
    pop      = 1'b0;
    if (rd_en_i) begin
      case (state)
        S_IDLE: begin
          if (empty) begin
            xd_nx = IDLE_D;
            xc_nx = '1;
          end else begin
            pop   = 1'b1;
            xd_nx = head_d;
            xc_nx = head_c;
            if (f_is_start(head_d, head_c) && !f_is_term(head_d, head_c)) state_nx = S_FRAME;
          end
        end
        S_FRAME: begin
          if (empty) begin
            xd_nx    = ERR_D;
            xc_nx    = '1;
            ur_nx    = 1'b1;
            state_nx = S_DRAIN;
          end else begin
            pop   = 1'b1;
            xd_nx = head_d;
            xc_nx = head_c;
            if (f_is_term(head_d, head_c)) state_nx = S_IDLE;
          end
        end
        S_DRAIN: begin
          // Poisoned frame: discard everything up to and including its terminate.
          xd_nx = ERR_D;
          xc_nx = '1;
          if (!empty) begin
            pop = 1'b1;
            if (f_is_term(head_d, head_c)) state_nx = S_IDLE;
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge TX_CLK) begin
    if (rst_s_i) begin
      state           <= S_IDLE;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      XD_O            <= IDLE_D;
      XC_O            <= '1;
      overflow_o      <= 1'b0;
      underrun_o      <= 1'b0;
      idle_drop_cnt_o <= '0;
      underrun_cnt_o  <= '0;
    end else begin
      state      <= state_nx;
      XD_O       <= xd_nx;
      XC_O       <= xc_nx;
      underrun_o <= ur_nx;
      overflow_o <= VALID && !READY && !in_idle;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
      if (VALID && !READY && in_idle && (idle_drop_cnt_o != 16'hFFFF))
        idle_drop_cnt_o <= idle_drop_cnt_o + 16'd1;
      if (ur_nx && (underrun_cnt_o != 16'hFFFF))
        underrun_cnt_o <= underrun_cnt_o + 16'd1;
    end
  end

endmodule

// File: doc/xgmii_tx_rate_fifo.md
Name: xgmii_tx_rate_fifo

Overview:
Parametrised XGMII transmit buffer between the MAC-side XGMII source and the PCS encoder. Accepts TXD/TXC words with a VALID/READY handshake and buffers them in a DEPTH-entry FIFO. Emits a continuous XGMII word stream on PCS demand, inserting idles between frames and error words on mid-frame underrun. Idle words offered while the FIFO is above threshold are deleted instead of stalling; this is the rate-matching mechanism.

Parameters:
LANES, 8, bytes per XGMII word; legal values 4 or 8.
DEPTH, 16, FIFO entries; power of 2, minimum 4.
AFULL, DEPTH-4, level at or above which READY deasserts; must satisfy 1 <= AFULL <= DEPTH.

Ports:
TX_CLK  in  1  clock; all logic on rising edge.
rst_s_i  in  1  synchronous reset, active-high.
TXD  in  8*LANES  transmit data; byte i is TXD[8i+7:8i].
TXC  in  LANES  transmit control; TXC[i]=1 means byte i is a control character.
VALID  in  1  TXD/TXC hold a word this cycle.
READY  out  1  buffer accepts a word this cycle.
rd_en_i  in  1  PCS consumes one output word this cycle.
XD_O  out  8*LANES  output data.
XC_O  out  LANES  output control.
level_o  out  $clog2(DEPTH)+1  current FIFO occupancy.
overflow_o  out  1  one-cycle pulse: non-idle word refused.
underrun_o  out  1  one-cycle pulse: FIFO empty while in frame.
idle_drop_cnt_o  out  16  saturating count of deleted idle words.
underrun_cnt_o  out  16  saturating count of underrun events.

Behaviour:
- Clock is TX_CLK; reset is synchronous and active-high (rst_s_i). Reset value of every output: XD_O=all lanes 0x07, XC_O=all 1s, level_o=0, overflow_o=0, underrun_o=0, both counters=0, FSM=S_IDLE, FIFO empty. Reset mid-frame discards FIFO contents immediately; the next cycle outputs idle.
- READY is combinational and equals (level_o < AFULL). Because AFULL <= DEPTH, the FIFO never overfills.
- Push occurs when VALID && READY.
- An idle word has every TXC bit = 1 and every byte = 0x07.
- When VALID && !READY:
  - idle word: dropped, and idle_drop_cnt_o increments (saturates at 0xFFFF);
  - any other word: dropped, and overflow_o pulses the next cycle.
- Start word: TXC[0]=1 and byte0=0xFB. Terminate word: any lane i with TXC[i]=1 and byte i = 0xFD. A word that is both start and terminate counts as a complete frame.
- Output is registered. A pop occurs on rd_en_i only when the FIFO is non-empty. XD_O/XC_O update on the edge after rd_en_i. When rd_en_i=0, XD_O/XC_O hold their values.
- Push and pop in the same cycle leave level_o unchanged. Push and pop are legal at level 0: the pushed word is not visible to a pop in the same cycle.
- FSM states and behaviour on each rd_en_i:
  - S_IDLE:
    - empty: output idle.
    - non-empty: pop and output the word. A start word that is not also terminate moves to S_FRAME.
  - S_FRAME:
    - non-empty: pop and output. A terminate word moves to S_IDLE.
    - empty: output an error word (all bytes 0xFE, XC all 1), pulse underrun_o, increment underrun_cnt_o (saturating), move to S_DRAIN.
  - S_DRAIN:
    - Output error words every cycle.
    - Words popped when non-empty are discarded.
    - Popping a terminate word outputs error and moves to S_IDLE.
    - A start word popped in S_DRAIN is also discarded.
- LANES=4 uses the identical rules with 32-bit data and 4-bit control.

Test Plan:
1. Reset, then rd_en_i=1 with no input for 5 cycles -> XD_O=0x0707070707070707, XC_O=0xFF, level_o=0, READY=1.
2. Push 1 start word (0xFB lane0), 6 data words, 1 terminate word (0xFD lane3), with rd_en_i held low; then rd_en_i=1 for 10 cycles -> level_o reaches 8; all 8 words appear in order one cycle after each pop; then idles; no pulses.
3. With rd_en_i=0, push 12 words to reach AFULL=12, then offer 3 idle words and 1 data word -> READY=0; idle_drop_cnt_o=3; overflow_o pulses once; level_o stays 12.
4. Start word plus 2 data words popped, then FIFO empty with rd_en_i=1 -> error word 0xFEFE…FE/0xFF, underrun_o pulse, underrun_cnt_o=1. Then push 2 data words and a terminate -> outputs error words while draining, then idle.
5. Simultaneous push and pop each cycle for 20 cycles at level 3 -> level_o constant 3, data order preserved.
6. Assert rst_s_i mid-frame at level 5 -> the next cycle shows level_o=0 and idle output; counters cleared to 0.
